// File: rtl/dds_multi.sv
// dds_multi: parametrised multi-mode direct digital synthesiser.
//
// A phase accumulator advances by freq_act every enabled cycle. A phase
// offset is added for output only, and the result is shaped into a ramp,
// square, triangle or pulse sample. New frequency words are taken through a
// valid/ready handshake and held pending until a phase wrap, a sync, or a
// stalled accumulator (freq_act == 0), so the output never glitches mid-period.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   en         in   1 = accumulate, 0 = hold phase
//   sync       in   zero the accumulator at the next edge (priority over en)
//   freq_in    in   [FREQ_W] offered frequency increment
//   freq_valid in   freq_in offered
//   freq_ready out  high when no word is pending; accepts freq_in
//   mode       in   [2] 00 ramp, 01 square, 10 triangle, 11 pulse
//   duty       in   [OUT_W] pulse threshold
//   phase_off  in   [ACC_W] output-only phase offset
//   wave_out   out  [OUT_W] registered waveform sample
//   square_out out  registered MSB of the offset phase
//   wrap       out  one-cycle pulse after an accumulator overflow
module dds_multi #(
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned FREQ_W = 16,
    parameter int unsigned OUT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sync,
    input  logic [FREQ_W-1:0] freq_in,
    input  logic              freq_valid,
    output logic              freq_ready,
    input  logic [1:0]        mode,
    input  logic [OUT_W-1:0]  duty,
    input  logic [ACC_W-1:0]  phase_off,
    output logic [OUT_W-1:0]  wave_out,
    output logic              square_out,
    output logic              wrap
);

    localparam int unsigned PAD_W = ACC_W + 1 - FREQ_W;
    localparam int unsigned LOW_W = ACC_W - OUT_W - 1;

    typedef enum logic [1:0] {
        MODE_RAMP   = 2'b00,
        MODE_SQUARE = 2'b01,
        MODE_TRI    = 2'b10,
        MODE_PULSE  = 2'b11
    } mode_t;

    logic [ACC_W-1:0]  acc;
    logic [FREQ_W-1:0] freq_act;
    logic [FREQ_W-1:0] freq_pend;
    logic              pending;

    logic [ACC_W:0]    sum;
    logic              wrap_evt;
    logic              apply;
    logic              accept;

    // Only the top OUT_W+1 bits of the offset phase shape the waveform.
    logic [OUT_W:0]    idx_top;
    logic [LOW_W-1:0]  idx_unused;
    logic [OUT_W-1:0]  t_val;
    logic [OUT_W-1:0]  u_val;
    logic              idx_msb;
    logic [OUT_W-1:0]  wave_next;
    mode_t             mode_sel;

    assign sum      = {1'b0, acc} + {{PAD_W{1'b0}}, freq_act};
    assign wrap_evt = en & ~sync & sum[ACC_W];

    assign freq_ready = ~pending;
    assign accept     = freq_valid & ~pending;
    // A stalled accumulator never wraps, so it must apply its update directly.
    assign apply      = pending & (wrap_evt | sync | (freq_act == '0));

    assign {idx_top, idx_unused} = acc + phase_off;
    assign idx_msb  = idx_top[OUT_W];
    assign t_val    = idx_top[OUT_W:1];
    assign u_val    = idx_top[OUT_W-1:0];
    assign mode_sel = mode_t'(mode);

    always_comb begin
        wave_next = '0;
        case (mode_sel)
            MODE_RAMP:   wave_next = t_val;
            MODE_SQUARE: wave_next = idx_msb ? '1 : '0;
            MODE_TRI:    wave_next = idx_msb ? ~u_val : u_val;
            MODE_PULSE:  wave_next = (t_val < duty) ? '1 : '0;
            default:     wave_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            freq_act   <= '0;
            freq_pend  <= '0;
            pending    <= 1'b0;
            wave_out   <= '0;
            square_out <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            if (sync) begin
                acc <= '0;
            end else if (en) begin
                acc <= sum[ACC_W-1:0];
            end

            wrap <= wrap_evt;

            // accept needs !pending and apply needs pending, so they never
            // fire on the same edge.
            if (apply) begin
                freq_act <= freq_pend;
                pending  <= 1'b0;
            end else if (accept) begin
                freq_pend <= freq_in;
                pending   <= 1'b1;
            end

            wave_out   <= wave_next;
            square_out <= idx_msb;
        end
    end

endmodule

// File: tb/tb_dds_multi.sv
// Self-checking bench for dds_multi (ACC_W=24, FREQ_W=16, OUT_W=6).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dds_multi;

    localparam int ACC_W  = 24;
    localparam int FREQ_W = 16;
    localparam int OUT_W  = 6;
    localparam int PERIOD = 4096;

    logic              clk;
    logic              reset;
    logic              en;
    logic              sync;
    logic [FREQ_W-1:0] freq_in;
    logic              freq_valid;
    logic              freq_ready;
    logic [1:0]        mode;
    logic [OUT_W-1:0]  duty;
    logic [ACC_W-1:0]  phase_off;
    logic [OUT_W-1:0]  wave_out;
    logic              square_out;
    logic              wrap;

    dds_multi #(
        .ACC_W (ACC_W),
        .FREQ_W(FREQ_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .sync      (sync),
        .freq_in   (freq_in),
        .freq_valid(freq_valid),
        .freq_ready(freq_ready),
        .mode      (mode),
        .duty      (duty),
        .phase_off (phase_off),
        .wave_out  (wave_out),
        .square_out(square_out),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string name;
        int    exp;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [1:0]       mode;
        logic [OUT_W-1:0] duty;
        logic [ACC_W-1:0] off;
        int               wave;
        int               sq;
    } vec_t;

    vec_t tbl[12];

    int wv  [PERIOD];
    int sqv [PERIOD];
    int sq0 [PERIOD];

    task automatic expect_val(input string name, input int exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic compare_next(input int act);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty got=%0d", act);
        end else begin
            e = sb.pop_front();
            if (act != e.exp) begin
                failures++;
                $display("FAIL %s got=%0d expected=%0d", e.name, act, e.exp);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        expect_val(name, exp);
        compare_next(act);
    endtask

    // Cycles until wrap is seen high; -1 if the budget expires.
    task automatic wait_wrap(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (wrap) begin
                n = i;
                return;
            end
        end
    endtask

    // Cycles until wave_out differs from its value on entry; -1 on timeout.
    task automatic run_len(input int budget, output int n);
        int v0;
        v0 = int'(wave_out);
        n  = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (int'(wave_out) != v0) begin
                n = i;
                return;
            end
        end
    endtask

    // Capture one full period; sample 0 is the cycle currently showing wrap.
    task automatic collect();
        for (int k = 0; k < PERIOD; k++) begin
            if (k > 0) @(negedge clk);
            wv[k]  = int'(wave_out);
            sqv[k] = int'(square_out);
        end
    endtask

    task automatic offer(input logic [FREQ_W-1:0] f);
        freq_in    = f;
        freq_valid = 1'b1;
        @(negedge clk);
        freq_valid = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        int cnt;
        int ref_wave;
        int ref_sq;
        int hist[64];

        tbl[0]  = '{2'b00, 6'd0,  24'h000000, 0,  0};
        tbl[1]  = '{2'b00, 6'd0,  24'h840000, 33, 1};
        tbl[2]  = '{2'b01, 6'd0,  24'h800000, 63, 1};
        tbl[3]  = '{2'b01, 6'd0,  24'h7FFFFF, 0,  0};
        tbl[4]  = '{2'b10, 6'd0,  24'h100000, 8,  0};
        tbl[5]  = '{2'b10, 6'd0,  24'h900000, 55, 1};
        tbl[6]  = '{2'b10, 6'd0,  24'hFE0000, 0,  1};
        tbl[7]  = '{2'b11, 6'd16, 24'h3C0000, 63, 0};
        tbl[8]  = '{2'b11, 6'd16, 24'h400000, 0,  0};
        tbl[9]  = '{2'b11, 6'd0,  24'h000000, 0,  0};
        tbl[10] = '{2'b11, 6'd63, 24'hF80000, 63, 1};
        tbl[11] = '{2'b00, 6'd0,  24'hFFFFFF, 63, 1};

        reset      = 1'b1;
        en         = 1'b1;
        sync       = 1'b0;
        freq_in    = '0;
        freq_valid = 1'b0;
        mode       = 2'b00;
        duty       = '0;
        phase_off  = '0;

        repeat (3) @(negedge clk);
        chk("reset_wave", int'(wave_out), 0);
        chk("reset_square", int'(square_out), 0);
        chk("reset_wrap", int'(wrap), 0);
        chk("reset_ready", int'(freq_ready), 1);
        reset = 1'b0;
        @(negedge clk);

        // Waveform shaping with the accumulator parked at 0 (freq_act == 0).
        for (int i = 0; i < 12; i++) begin
            mode      = tbl[i].mode;
            duty      = tbl[i].duty;
            phase_off = tbl[i].off;
            expect_val($sformatf("table%0d_wave", i), tbl[i].wave);
            expect_val($sformatf("table%0d_square", i), tbl[i].sq);
            @(negedge clk);
            compare_next(int'(wave_out));
            compare_next(int'(square_out));
        end

        // Start from stall.
        mode      = 2'b00;
        duty      = '0;
        phase_off = '0;
        offer(16'h1000);
        chk("stall_ready_low", int'(freq_ready), 0);
        @(negedge clk);
        chk("stall_ready_back", int'(freq_ready), 1);
        wait_wrap(5000, n);
        chk("stall_first_wrap_seen", int'(n > 0), 1);
        wait_wrap(5000, n);
        chk("stall_wrap_interval", n, 4096);
        run_len(200, n);
        chk("ramp_first_change", n, 1);
        chk("ramp_after_wrap", int'(wave_out), 0);
        run_len(200, n);
        chk("ramp_step_len", n, 64);
        chk("ramp_step_value", int'(wave_out), 1);

        // Update while running.
        wait_wrap(5000, n);
        chk("upd_wrap_seen", int'(n > 0), 1);
        repeat (1024) @(negedge clk);
        freq_in    = 16'h2000;
        freq_valid = 1'b1;
        bad        = 0;
        @(negedge clk);
        chk("upd_ready_low", int'(freq_ready), 0);
        freq_in = 16'h3000;
        repeat (3) begin
            @(negedge clk);
            if (freq_ready) bad++;
        end
        freq_valid = 1'b0;
        n = -1;
        for (int i = 1; i <= 5000; i++) begin
            @(negedge clk);
            if (wrap) begin
                n = i;
                break;
            end
            if (freq_ready) bad++;
        end
        chk("upd_wrap_reached", int'(n > 0), 1);
        chk("upd_ready_low_until_wrap", bad, 0);
        chk("upd_ready_at_wrap", int'(freq_ready), 1);
        wait_wrap(5000, n);
        chk("upd_wrap_interval", n, 2048);

        // Triangle at 0x1000.
        offer(16'h1000);
        mode = 2'b10;
        wait_wrap(5000, n);
        chk("tri_wrap_seen", int'(n > 0), 1);
        collect();
        for (int v = 0; v < 64; v++) hist[v] = 0;
        for (int k = 0; k < PERIOD; k++) hist[wv[k]]++;
        bad = 0;
        for (int v = 0; v < 64; v++) if (hist[v] != 64) bad++;
        chk("tri_hist", bad, 0);
        chk("tri_hold_63", hist[63], 64);
        chk("tri_hold_0", hist[0], 64);
        bad = 0;
        for (int k = 2; k <= 2048; k++) if (wv[k] < wv[k-1]) bad++;
        chk("tri_rising", bad, 0);
        bad = 0;
        for (int k = 2049; k < PERIOD; k++) if (wv[k] > wv[k-1]) bad++;
        chk("tri_falling", bad, 0);
        chk("tri_mid_value", wv[1025], 32);
        @(negedge clk);
        chk("tri_period", int'(wrap), 1);

        // Pulse, duty 16.
        mode = 2'b11;
        duty = 6'd16;
        wait_wrap(5000, n);
        chk("pulse16_wrap", n, 4096);
        collect();
        cnt = 0;
        bad = 0;
        for (int k = 0; k < PERIOD; k++) begin
            if (wv[k] == 63) cnt++;
            else if (wv[k] != 0) bad++;
        end
        chk("pulse16_high", cnt, 1024);
        chk("pulse16_levels", bad, 0);
        @(negedge clk);
        chk("pulse16_period", int'(wrap), 1);

        // Pulse, duty 0.
        duty = '0;
        wait_wrap(5000, n);
        chk("pulse0_wrap", n, 4096);
        collect();
        cnt = 0;
        for (int k = 0; k < PERIOD; k++) begin
            if (wv[k] != 0) cnt++;
            sq0[k] = sqv[k];
        end
        chk("pulse0_high", cnt, 0);
        chk("sq0_after_wrap", sq0[1], 0);
        chk("sq0_half", sq0[2049], 1);
        @(negedge clk);

        // Half-turn phase offset inverts square_out.
        phase_off = 24'h800000;
        wait_wrap(5000, n);
        chk("off_wrap", n, 4096);
        collect();
        bad = 0;
        for (int k = 0; k < PERIOD; k++) if (sqv[k] == sq0[k]) bad++;
        chk("off_square_inverted", bad, 0);
        phase_off = '0;
        mode      = 2'b00;
        @(negedge clk);
        chk("off_period", int'(wrap), 1);

        // Enable hold for 100 cycles.
        repeat (500) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        ref_wave = int'(wave_out);
        ref_sq   = int'(square_out);
        chk("hold_ref_wave", ref_wave, 7);
        bad = 0;
        repeat (99) begin
            @(negedge clk);
            if (int'(wave_out) != ref_wave || int'(square_out) != ref_sq || wrap) bad++;
        end
        chk("hold_frozen", bad, 0);
        en = 1'b1;
        wait_wrap(5000, n);
        chk("hold_resume_wrap", n, 3596);

        // Sync with a pending word.
        offer(16'h4000);
        repeat (200) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        chk("sync_no_wrap", int'(wrap), 0);
        chk("sync_ready", int'(freq_ready), 1);
        @(negedge clk);
        chk("sync_wave_zero", int'(wave_out), 0);
        chk("sync_square_zero", int'(square_out), 0);
        wait_wrap(5000, n);
        chk("sync_first_wrap", n, 1023);
        wait_wrap(5000, n);
        chk("sync_new_interval", n, 1024);

        // Sync coinciding with an overflow carry.
        offer(16'h1000);
        repeat (1022) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        chk("coinc_no_wrap", int'(wrap), 0);
        chk("coinc_ready", int'(freq_ready), 1);
        wait_wrap(5000, n);
        chk("coinc_next_wrap", n, 4096);

        // Reset mid-operation with a pending word.
        mode      = 2'b01;
        phase_off = 24'h800000;
        offer(16'h2000);
        repeat (10) @(negedge clk);
        chk("pre_reset_wave", int'(wave_out), 63);
        chk("pre_reset_pending", int'(freq_ready), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_wave", int'(wave_out), 0);
        chk("midreset_square", int'(square_out), 0);
        chk("midreset_wrap", int'(wrap), 0);
        chk("midreset_ready", int'(freq_ready), 1);
        reset     = 1'b0;
        mode      = 2'b00;
        phase_off = '0;
        bad       = 0;
        repeat (300) begin
            @(negedge clk);
            if (wave_out != '0 || wrap || !freq_ready) bad++;
        end
        chk("midreset_stalled", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
